ad_sample_averager: RTL

//  Downstream consumer of the AD7266 dual-channel serial reader. Captures one A/B
//  12-bit two's-complement sample pair (differential mode) per conversion frame, on
//  the rd_done strobe. Box-car averages 2**LOG2_N pairs and emits one averaged pair

---
 rtl/ad_pkg.sv | 31 +++
 rtl/ad_strobe_sync.sv | 28 ++
 rtl/ad_sample_averager.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ad_pkg.sv
// Shared types and helpers for the AD7266 sample averager.
// Holds the sample width, FSM state encoding and sign/abs helpers.
package ad_pkg;

    localparam int AD_DATA_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_OUTPUT
    } ad_state_e;

    function automatic logic signed [31:0] sign_ext(
        input logic [AD_DATA_W-1:0] x
    );
        return 32'(signed'(x));
    endfunction

    // |x| with the most negative code clamped to the largest positive code
    function automatic logic [AD_DATA_W-1:0] abs_sat(
        input logic [AD_DATA_W-1:0] x
    );
        logic [AD_DATA_W-1:0] n;
        n = -x;
        if (!x[AD_DATA_W-1]) return x;
        if (n[AD_DATA_W-1]) return {1'b0, {(AD_DATA_W-1){1'b1}}};
        return n;
    endfunction

endpackage

// File: rtl/ad_strobe_sync.sv
// Two-flop synchronizer for the reader's frame-done strobe,
// followed by a falling-edge detector producing a 1-cycle pulse.
module ad_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign fall_o = s3_q & ~s2_q;

endmodule

// File: rtl/ad_sample_averager.sv
// Box-car averager of 2**LOG2_N A/B sample pairs from the AD7266 reader.
// Optional per-channel peak-|x| hold is built when PEAK_HOLD_EN is defined.
module ad_sample_averager
    import ad_pkg::*;
#(
    parameter int DATA_W = AD_DATA_W,
    parameter int LOG2_N = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rd_done_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] avg_a,
    output logic [DATA_W-1:0] avg_b,
    output logic              avg_valid,
    output logic [LOG2_N-1:0] frame_cnt,
    output logic [DATA_W-1:0] peak_a,
    output logic [DATA_W-1:0] peak_b
);

    localparam int ACC_W = DATA_W + LOG2_N;

    logic              cap_stb;
    ad_state_e         state_q, state_d;
    logic [ACC_W-1:0]  acc_a_q, acc_a_d;
    logic [ACC_W-1:0]  acc_b_q, acc_b_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] avg_a_q, avg_a_d;
    logic [DATA_W-1:0] avg_b_q, avg_b_d;
    logic              vld_q, vld_d;
    logic              cap_ovr_q, cap_ovr_d;
    logic [ACC_W-1:0]  sum_a;
    logic [ACC_W-1:0]  sum_b;

    ad_strobe_sync u_sync (
        .clk     (sys_clk),
        .rst     (rst),
        .async_i (rd_done_in),
        .fall_o  (cap_stb)
    );

    assign sum_a = acc_a_q + ACC_W'(sign_ext(a_in));
    assign sum_b = acc_b_q + ACC_W'(sign_ext(b_in));

    // The average is registered on the final CAPTURE so that it is
    // presented together with avg_valid during the OUTPUT cycle.
    always_comb begin
        state_d   = state_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        cnt_d     = cnt_q;
        avg_a_d   = avg_a_q;
        avg_b_d   = avg_b_q;
        vld_d     = 1'b0;
        cap_ovr_d = cap_ovr_q;
        if (cap_stb && (state_q == ST_CAPTURE || state_q == ST_OUTPUT))
            cap_ovr_d = 1'b1;
        if (!en) begin
            state_d = ST_IDLE;
            acc_a_d = '0;
            acc_b_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                ST_WAIT: if (cap_stb) state_d = ST_CAPTURE;
                ST_CAPTURE: begin
                    acc_a_d = sum_a;
                    acc_b_d = sum_b;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_WAIT;
                    if (cnt_q == '1) begin
                        avg_a_d = sum_a[ACC_W-1:LOG2_N];
                        avg_b_d = sum_b[ACC_W-1:LOG2_N];
                        vld_d   = 1'b1;
                        state_d = ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    acc_a_d = '0;
                    acc_b_d = '0;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            cnt_q     <= '0;
            avg_a_q   <= '0;
            avg_b_q   <= '0;
            vld_q     <= 1'b0;
            cap_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
            cnt_q     <= cnt_d;
            avg_a_q   <= avg_a_d;
            avg_b_q   <= avg_b_d;
            vld_q     <= vld_d;
            cap_ovr_q <= cap_ovr_d;
        end
    end

    assign avg_a     = avg_a_q;
    assign avg_b     = avg_b_q;
    assign avg_valid = vld_q;
    assign frame_cnt = cnt_q;

`ifdef PEAK_HOLD_EN
    logic              pk_cap;
    logic              pk_last;
    logic [DATA_W-1:0] abs_a, abs_b, max_a, max_b;
    logic [DATA_W-1:0] run_a_q, run_a_d, run_b_q, run_b_d;
    logic [DATA_W-1:0] peak_a_q, peak_a_d, peak_b_q, peak_b_d;

    assign pk_cap  = en && (state_q == ST_CAPTURE);
    assign pk_last = pk_cap && (cnt_q == '1);
    assign abs_a   = abs_sat(a_in);
    assign abs_b   = abs_sat(b_in);
    assign max_a   = (abs_a > run_a_q) ? abs_a : run_a_q;
    assign max_b   = (abs_b > run_b_q) ? abs_b : run_b_q;

    always_comb begin
        run_a_d  = run_a_q;
        run_b_d  = run_b_q;
        peak_a_d = peak_a_q;
        peak_b_d = peak_b_q;
        if (!en) begin
            run_a_d = '0;
            run_b_d = '0;
        end else if (pk_last) begin
            peak_a_d = max_a;
            peak_b_d = max_b;
            run_a_d  = '0;
            run_b_d  = '0;
        end else if (pk_cap) begin
            run_a_d = max_a;
            run_b_d = max_b;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            run_a_q  <= '0;
            run_b_q  <= '0;
            peak_a_q <= '0;
            peak_b_q <= '0;
        end else begin
            run_a_q  <= run_a_d;
            run_b_q  <= run_b_d;
            peak_a_q <= peak_a_d;
            peak_b_q <= peak_b_d;
        end
    end

    assign peak_a = peak_a_q;
    assign peak_b = peak_b_q;
`else
    assign peak_a = '0;
    assign peak_b = '0;
`endif

endmodule
